riscv_multicycle_ctrl: RTL and testbench

RISCV_MULTICYCLE_CTRL -- requirements
Module: riscv_multicycle_ctrl

---
 rtl/riscv_multicycle_ctrl_if.sv | 32 +++
 rtl/riscv_multicycle_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_riscv_multicycle_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/riscv_multicycle_ctrl_if.sv
// Control bus between the multicycle controller and its datapath.
// master: controller side (reads instruction fields/flags, drives control).
// slave : datapath side (drives instruction fields/flags, reads control).
interface riscv_multicycle_ctrl_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;

    modport master (
        input  op, funct3, funct7b5, Zero, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl
    );

    modport slave (
        output op, funct3, funct7b5, Zero, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl
    );
endinterface

// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle RISC-V (RV32I subset) main controller with retired-instruction counter.
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-low reset
//   bus       - control bus (master): op/funct3/funct7b5/Zero/MemReady in,
//               datapath control strobes and selects out (decoded from state)
//   State_DBG - current FSM state encoding
//   Retired   - completed-instruction count, wraps modulo 2^CNT_W
module riscv_multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    riscv_multicycle_ctrl_if.master    bus,
    output logic [3:0]                 State_DBG,
    output logic [CNT_W-1:0]           Retired
);

    localparam logic [3:0] FETCH   = 4'd0;
    localparam logic [3:0] DECODE  = 4'd1;
    localparam logic [3:0] MEMADR  = 4'd2;
    localparam logic [3:0] MEMREAD = 4'd3;
    localparam logic [3:0] MEMWB   = 4'd4;
    localparam logic [3:0] MEMWR   = 4'd5;
    localparam logic [3:0] EXER    = 4'd6;
    localparam logic [3:0] EXEI    = 4'd7;
    localparam logic [3:0] JAL     = 4'd8;
    localparam logic [3:0] ALUWB   = 4'd9;
    localparam logic [3:0] BEQ     = 4'd10;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [3:0] state;
    logic [3:0] state_next;
    logic       pc_update;
    logic       branch;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       retire;
    logic [1:0] alu_op;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-state control decode
    always_comb begin
        state_next    = state;
        pc_update     = 1'b0;
        branch        = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        retire        = 1'b0;
        alu_op        = 2'b00;
        bus.AdrSrc    = 1'b0;
        bus.ResultSrc = 2'b00;
        bus.ALUSrcA   = 2'b00;
        bus.ALUSrcB   = 2'b00;
        case (state)
            FETCH: begin
                bus.ResultSrc = 2'b10;
                bus.ALUSrcB   = 2'b10;
                ir_write      = bus.MemReady;
                pc_update     = bus.MemReady;
                if (bus.MemReady) state_next = DECODE;
            end
            DECODE: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
                case (bus.op)
                    OP_LOAD, OP_STORE: state_next = MEMADR;
                    OP_RTYPE:          state_next = EXER;
                    OP_ITYPE:          state_next = EXEI;
                    OP_BRANCH:         state_next = BEQ;
                    OP_JAL:            state_next = JAL;
                    default: begin
                        // Unsupported opcode is dropped and counted as retired
                        state_next = FETCH;
                        retire     = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                state_next  = bus.op[5] ? MEMWR : MEMREAD;
            end
            MEMREAD: begin
                bus.AdrSrc = 1'b1;
                if (bus.MemReady) state_next = MEMWB;
            end
            MEMWB: begin
                bus.ResultSrc = 2'b01;
                reg_write     = 1'b1;
                retire        = 1'b1;
                state_next    = FETCH;
            end
            MEMWR: begin
                bus.AdrSrc = 1'b1;
                mem_write  = 1'b1;
                if (bus.MemReady) begin
                    state_next = FETCH;
                    retire     = 1'b1;
                end
            end
            EXER: begin
                bus.ALUSrcA = 2'b10;
                alu_op      = 2'b10;
                state_next  = ALUWB;
            end
            EXEI: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                alu_op      = 2'b10;
                state_next  = ALUWB;
            end
            JAL: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
                pc_update   = 1'b1;
                state_next  = ALUWB;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
            end
            BEQ: begin
                bus.ALUSrcA = 2'b10;
                alu_op      = 2'b01;
                branch      = 1'b1;
                retire      = 1'b1;
                state_next  = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    // Write strobes are gated by reset so they drop the instant reset asserts
    assign bus.PCWrite  = rst & (pc_update | (branch & bus.Zero));
    assign bus.MemWrite = rst & mem_write;
    assign bus.IRWrite  = rst & ir_write;
    assign bus.RegWrite = rst & reg_write;

    // Immediate format from opcode
    always_comb begin
        bus.ImmSrc = 2'b00;
        case (bus.op)
            OP_STORE:  bus.ImmSrc = 2'b01;
            OP_BRANCH: bus.ImmSrc = 2'b10;
            OP_JAL:    bus.ImmSrc = 2'b11;
            default:   bus.ImmSrc = 2'b00;
        endcase
    end

    // ALU decoder; sub only for R-type (op[5]) with funct7b5 set
    always_comb begin
        bus.ALUControl = 3'b000;
        case (alu_op)
            2'b01: bus.ALUControl = 3'b001;
            2'b10: begin
                case (bus.funct3)
                    3'b000:  bus.ALUControl = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  bus.ALUControl = 3'b101;
                    3'b110:  bus.ALUControl = 3'b011;
                    3'b111:  bus.ALUControl = 3'b010;
                    default: bus.ALUControl = 3'b000;
                endcase
            end
            default: bus.ALUControl = 3'b000;
        endcase
    end

    // Retired-instruction counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Retired <= '0;
        end else if (retire) begin
            Retired <= Retired + CNT_W'(1);
        end
    end

    assign State_DBG = state;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Self-checking bench for riscv_multicycle_ctrl: directed and random instructions
// compared cycle by cycle against an instruction-level reference model.
module tb_riscv_multicycle_ctrl;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4,
                   S_MEMWR = 5, S_EXER = 6, S_EXEI = 7, S_JAL = 8, S_ALUWB = 9, S_BEQ = 10;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic       clk;
    logic       rst;
    logic [3:0] State_DBG;
    logic [3:0] Retired;

    int checks  = 0;
    int errors  = 0;
    int retired = 0;

    riscv_multicycle_ctrl_if bus ();

    riscv_multicycle_ctrl #(.CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .State_DBG (State_DBG),
        .Retired   (Retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_known(input logic [6:0] o);
        return (o == OP_LW) || (o == OP_SW) || (o == OP_R) || (o == OP_I) ||
               (o == OP_BEQ) || (o == OP_JAL);
    endfunction

    // Expected {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB} and ALUOp
    function automatic void exp_ctrl(input int st, input logic mr, input logic z,
                                     output logic [10:0] v, output logic [1:0] aop);
        logic pcw, adr, mw, ir, rw;
        logic [1:0] rs, a, b;
        pcw = 0; adr = 0; mw = 0; ir = 0; rw = 0; rs = 2'b00; a = 2'b00; b = 2'b00; aop = 2'b00;
        case (st)
            S_FETCH:   begin pcw = mr; ir = mr; rs = 2'b10; b = 2'b10; end
            S_DECODE:  begin a = 2'b01; b = 2'b01; end
            S_MEMADR:  begin a = 2'b10; b = 2'b01; end
            S_MEMREAD: adr = 1;
            S_MEMWB:   begin rs = 2'b01; rw = 1; end
            S_MEMWR:   begin adr = 1; mw = 1; end
            S_EXER:    begin a = 2'b10; aop = 2'b10; end
            S_EXEI:    begin a = 2'b10; b = 2'b01; aop = 2'b10; end
            S_JAL:     begin pcw = 1; a = 2'b01; b = 2'b10; end
            S_ALUWB:   rw = 1;
            S_BEQ:     begin pcw = z; a = 2'b10; aop = 2'b01; end
            default:   ;
        endcase
        v = {pcw, adr, mw, ir, rw, rs, a, b};
    endfunction

    function automatic logic [2:0] exp_alu(input logic [1:0] aop, input logic [6:0] o,
                                           input logic [2:0] f3, input logic f7);
        if (aop == 2'b01) return 3'b001;
        if (aop != 2'b10) return 3'b000;
        case (f3)
            3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] o);
        if (o == OP_SW)  return 2'b01;
        if (o == OP_BEQ) return 2'b10;
        if (o == OP_JAL) return 2'b11;
        return 2'b00;
    endfunction

    // Run one instruction: fw fetch stalls, mw memory stalls, checked every cycle
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input int fw, input int mw);
        int sq[$];
        bit mq[$];
        logic [10:0] ev;
        logic [1:0] aop;
        for (int i = 0; i < fw; i++) begin sq.push_back(S_FETCH); mq.push_back(1'b0); end
        sq.push_back(S_FETCH);  mq.push_back(1'b1);
        sq.push_back(S_DECODE); mq.push_back(bit'($urandom_range(0, 1)));
        if (o == OP_LW || o == OP_SW) begin
            sq.push_back(S_MEMADR); mq.push_back(bit'($urandom_range(0, 1)));
            for (int i = 0; i < mw; i++) begin
                sq.push_back(o == OP_LW ? S_MEMREAD : S_MEMWR); mq.push_back(1'b0);
            end
            sq.push_back(o == OP_LW ? S_MEMREAD : S_MEMWR); mq.push_back(1'b1);
            if (o == OP_LW) begin sq.push_back(S_MEMWB); mq.push_back(bit'($urandom_range(0, 1))); end
        end else if (o == OP_R || o == OP_I || o == OP_JAL) begin
            sq.push_back(o == OP_R ? S_EXER : (o == OP_I ? S_EXEI : S_JAL));
            mq.push_back(bit'($urandom_range(0, 1)));
            sq.push_back(S_ALUWB); mq.push_back(bit'($urandom_range(0, 1)));
        end else if (o == OP_BEQ) begin
            sq.push_back(S_BEQ); mq.push_back(bit'($urandom_range(0, 1)));
        end
        bus.op = o; bus.funct3 = f3; bus.funct7b5 = f7; bus.Zero = z;
        foreach (sq[i]) begin
            @(negedge clk);
            bus.MemReady = mq[i];
            #1;
            check($sformatf("state op=%b step%0d", o, i), 32'(State_DBG), 32'(sq[i]));
            exp_ctrl(sq[i], mq[i], z, ev, aop);
            check($sformatf("ctrl st=%0d", sq[i]),
                  32'({bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                       bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB}), 32'(ev));
            check($sformatf("alu st=%0d f3=%0d", sq[i], f3), 32'(bus.ALUControl),
                  32'(exp_alu(aop, o, f3, f7)));
            check("imm", 32'(bus.ImmSrc), 32'(exp_imm(o)));
        end
        retired++;
        @(negedge clk);
        bus.MemReady = 1'b0;
        #1;
        check("end_state", 32'(State_DBG), 32'(S_FETCH));
        check("retired", 32'(Retired), 32'(retired % 16));
    endtask

    task automatic run_random();
        logic [6:0] o;
        case ($urandom_range(0, 6))
            0: o = OP_LW;
            1: o = OP_SW;
            2: o = OP_R;
            3: o = OP_I;
            4: o = OP_BEQ;
            5: o = OP_JAL;
            default: begin
                o = 7'($urandom);
                if (is_known(o)) o = 7'h7F;
            end
        endcase
        run_instr(o, 3'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    endtask

    initial begin
        rst = 1'b0;
        bus.op = 7'd0; bus.funct3 = 3'd0; bus.funct7b5 = 1'b0; bus.Zero = 1'b0;
        bus.MemReady = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_state", 32'(State_DBG), 32'(S_FETCH));
        check("reset_retired", 32'(Retired), 32'd0);
        check("reset_strobes", 32'({bus.PCWrite, bus.MemWrite, bus.IRWrite, bus.RegWrite}), 32'd0);
        rst = 1'b1;
        bus.MemReady = 1'b0;

        run_instr(OP_R, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr(OP_LW, 3'b010, 1'b0, 1'b0, 0, 3);
        run_instr(OP_BEQ, 3'b000, 1'b0, 1'b1, 0, 0);
        run_instr(OP_BEQ, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr(OP_SW, 3'b010, 1'b0, 1'b0, 0, 2);
        run_instr(7'h7F, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr(OP_R, 3'b000, 1'b1, 1'b0, 1, 0);
        run_instr(OP_I, 3'b000, 1'b1, 1'b0, 0, 0);
        run_instr(OP_R, 3'b110, 1'b0, 1'b0, 0, 0);
        run_instr(OP_I, 3'b111, 1'b0, 1'b0, 0, 0);
        run_instr(OP_R, 3'b010, 1'b0, 1'b0, 0, 0);
        run_instr(OP_JAL, 3'b000, 1'b0, 1'b0, 2, 0);

        for (int n = 0; n < 40; n++) run_random();

        // Asynchronous reset in the middle of a jal
        bus.op = OP_JAL; bus.Zero = 1'b0;
        @(negedge clk); bus.MemReady = 1'b1; #1;
        check("jal_fetch", 32'(State_DBG), 32'(S_FETCH));
        @(negedge clk); #1;
        check("jal_decode", 32'(State_DBG), 32'(S_DECODE));
        @(negedge clk); #1;
        check("jal_state", 32'(State_DBG), 32'(S_JAL));
        check("jal_pcwrite", 32'(bus.PCWrite), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("async_rst_state", 32'(State_DBG), 32'(S_FETCH));
        check("async_rst_retired", 32'(Retired), 32'd0);
        check("async_rst_strobes", 32'({bus.PCWrite, bus.MemWrite, bus.IRWrite, bus.RegWrite}), 32'd0);
        @(negedge clk); #1;
        check("rst_hold_state", 32'(State_DBG), 32'(S_FETCH));
        check("rst_hold_strobes", 32'({bus.PCWrite, bus.MemWrite, bus.IRWrite, bus.RegWrite}), 32'd0);
        rst = 1'b1;
        bus.MemReady = 1'b0;
        retired = 0;

        // Counter wrap at 2^4
        for (int n = 0; n < 15; n++) run_random();
        check("wrap_pre", 32'(Retired), 32'd15);
        run_instr(OP_R, 3'b000, 1'b0, 1'b0, 0, 0);
        check("wrap", 32'(Retired), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
